dac_serializer: RTL and testbench

- Transmit side of the audio sample path: accepts 16-bit filtered samples from the filter stage and shifts each one, MSB first, into an external serial DAC.
- Interface to the DAC is SPI-style: frame sync, serial clock, data.
- Sits between the filter chain's sample strobe and the board DAC pins.
- Paces the upstream with a ready signal and counts samples that arrive while a frame is still in flight.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/dac_serializer_if.sv | 24 ++
 rtl/dac_serializer_sclk_tick_gen.sv | 30 +++
 rtl/dac_serializer.sv | 98 +++++++++
 tb/tb_dac_serializer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and frame constants for the audio sample output path.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int SAMPLE_W           = 16;
  localparam int FRAME_HALF_PERIODS = 32;
  localparam int GAP_HALF_PERIODS   = 2;

  // Two's complement samples become offset binary by flipping the sign bit.
  function automatic logic [SAMPLE_W-1:0] to_dac_code(input logic [SAMPLE_W-1:0] s,
                                                      input bit signed_in);
    logic [SAMPLE_W-1:0] r;
    r = s;
    if (signed_in) r[SAMPLE_W-1] = ~s[SAMPLE_W-1];
    return r;
  endfunction

endpackage

// File: rtl/dac_serializer_if.sv
// Sample strobe from the filter chain plus the serial DAC pins and status.
interface dac_serializer_if;
  import audio_pkg::*;

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic                dac_sync_n;
  logic                dac_sclk;
  logic                dac_din;
  logic                busy;
  logic [7:0]          overrun_cnt;

  modport master (
    output sample_in, sample_valid,
    input  sample_ready, dac_sync_n, dac_sclk, dac_din, busy, overrun_cnt
  );

  modport slave (
    input  sample_in, sample_valid,
    output sample_ready, dac_sync_n, dac_sclk, dac_din, busy, overrun_cnt
  );

endinterface

// File: rtl/dac_serializer_sclk_tick_gen.sv
// Divider producing one tick every CLK_DIV clk cycles; each tick marks the
// end of one dac_sclk half period.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divide counter, restarted so a new frame gets full half periods.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/dac_serializer.sv
// Serialises 16-bit samples MSB first into an SPI-style DAC; drops and
// counts samples that arrive while a frame or its trailing gap is active.
module dac_serializer
  import audio_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter bit SIGNED_IN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  dac_serializer_if.slave bus
);

  state_t              state;
  logic [SAMPLE_W-1:0] shreg;
  logic [4:0]          hp_cnt;
  logic [SAMPLE_W-1:0] code;
  logic                accept;
  logic                tick;

  assign code   = to_dac_code(bus.sample_in, SIGNED_IN);
  assign accept = bus.sample_valid && bus.sample_ready;

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .tick  (tick)
  );

  // Frame FSM; every pin and status output is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      shreg            <= '0;
      hp_cnt           <= '0;
      bus.sample_ready <= 1'b1;
      bus.dac_sync_n   <= 1'b1;
      bus.dac_sclk     <= 1'b1;
      bus.dac_din      <= 1'b0;
      bus.busy         <= 1'b0;
      bus.overrun_cnt  <= '0;
    end else begin
      if (bus.sample_valid && !bus.sample_ready && bus.overrun_cnt != 8'hFF) begin
        bus.overrun_cnt <= bus.overrun_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            shreg            <= code;
            bus.dac_din      <= code[SAMPLE_W-1];
            hp_cnt           <= '0;
            bus.dac_sync_n   <= 1'b0;
            bus.dac_sclk     <= 1'b1;
            bus.sample_ready <= 1'b0;
            bus.busy         <= 1'b1;
            state            <= SHIFT;
          end
        end

        SHIFT: begin
          if (tick) begin
            bus.dac_sclk <= ~bus.dac_sclk;
            hp_cnt       <= hp_cnt + 5'd1;
            // Advance the word only as sclk returns high, after the DAC's falling-edge sample.
            if (!bus.dac_sclk) begin
              shreg       <= shreg << 1;
              bus.dac_din <= shreg[SAMPLE_W-2];
            end
            if (hp_cnt == 5'(FRAME_HALF_PERIODS - 1)) begin
              hp_cnt         <= '0;
              bus.dac_sync_n <= 1'b1;
              bus.dac_sclk   <= 1'b1;
              bus.dac_din    <= 1'b0;
              state          <= GAP;
            end
          end
        end

        GAP: begin
          if (tick) begin
            hp_cnt <= hp_cnt + 5'd1;
            if (hp_cnt == 5'(GAP_HALF_PERIODS - 1)) begin
              hp_cnt           <= '0;
              bus.sample_ready <= 1'b1;
              bus.busy         <= 1'b0;
              state            <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serializer.sv
// Bench: two serializers (CLK_DIV=2 signed, CLK_DIV=1 unsigned) with a
// frame monitor each and an expected-word scoreboard.
module tb_dac_serializer;
  import audio_pkg::*;

  localparam int CDS = 2;
  localparam int CDU = 1;

  typedef struct {
    logic [15:0] w;
    int          nf;
    int          sl;
  } frame_t;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_u;

  dac_serializer_if if_s ();
  dac_serializer_if if_u ();

  dac_serializer #(.CLK_DIV(CDS), .SIGNED_IN(1'b1)) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (if_s)
  );

  dac_serializer #(.CLK_DIV(CDU), .SIGNED_IN(1'b0)) dut_u (
    .clk (clk),
    .rst (rst_u),
    .bus (if_u)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_s[$];
  logic [15:0] exp_u[$];
  frame_t      obs_s[$];
  frame_t      obs_u[$];
  int free_s = 0;
  int free_u = 0;
  int ovr_u  = 0;
  int t0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive sample_valid for n cycles; the model decides accept vs. drop per edge.
  task automatic drive_s(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      if_s.sample_in    = d;
      if_s.sample_valid = 1'b1;
      if (cyc + 1 >= free_s) begin
        exp_s.push_back(d ^ 16'h8000);
        free_s = cyc + 1 + 34 * CDS + 1;
      end
      @(negedge clk);
    end
    if_s.sample_valid = 1'b0;
  endtask

  task automatic drive_u(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      if_u.sample_in    = d + 16'(i);
      if_u.sample_valid = 1'b1;
      if (cyc + 1 >= free_u) begin
        exp_u.push_back(d + 16'(i));
        free_u = cyc + 1 + 34 * CDU + 1;
      end else if (ovr_u < 255) begin
        ovr_u++;
      end
      @(negedge clk);
    end
    if_u.sample_valid = 1'b0;
  endtask

  task automatic wait_s(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (obs_s.size() >= exp_s.size()) break;
      @(negedge clk);
    end
    chk("s_frames", obs_s.size(), exp_s.size());
  endtask

  task automatic wait_u(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (obs_u.size() >= exp_u.size()) break;
      @(negedge clk);
    end
    chk("u_frames", obs_u.size(), exp_u.size());
  endtask

  task automatic drain_s();
    frame_t f;
    logic [15:0] e;
    while (exp_s.size() > 0 && obs_s.size() > 0) begin
      f = obs_s.pop_front();
      e = exp_s.pop_front();
      chk("s_word", f.w, e);
      chk("s_falls", f.nf, 16);
      chk("s_sync_len", f.sl, 32 * CDS);
    end
  endtask

  task automatic drain_u();
    frame_t f;
    logic [15:0] e;
    while (exp_u.size() > 0 && obs_u.size() > 0) begin
      f = obs_u.pop_front();
      e = exp_u.pop_front();
      chk("u_word", f.w, e);
      chk("u_falls", f.nf, 16);
      chk("u_sync_len", f.sl, 32 * CDU);
    end
  endtask

  // Frame capture: shift din in on each sclk fall while sync_n is low.
  initial begin : mon_s
    logic ps, pk;
    logic [15:0] w;
    int nf, sl;
    ps = 1'b1; pk = 1'b1; w = '0; nf = 0; sl = 0;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        ps = 1'b1; pk = 1'b1; w = '0; nf = 0; sl = 0;
      end else begin
        if (!if_s.dac_sync_n) begin
          sl++;
          if (pk && !if_s.dac_sclk) begin
            w = {w[14:0], if_s.dac_din};
            nf++;
          end
        end else if (!ps) begin
          obs_s.push_back('{w, nf, sl});
          w = '0; nf = 0; sl = 0;
        end
        ps = if_s.dac_sync_n;
        pk = if_s.dac_sclk;
      end
    end
  end

  initial begin : mon_u
    logic ps, pk;
    logic [15:0] w;
    int nf, sl;
    ps = 1'b1; pk = 1'b1; w = '0; nf = 0; sl = 0;
    forever begin
      @(negedge clk);
      if (rst_u) begin
        ps = 1'b1; pk = 1'b1; w = '0; nf = 0; sl = 0;
      end else begin
        if (!if_u.dac_sync_n) begin
          sl++;
          if (pk && !if_u.dac_sclk) begin
            w = {w[14:0], if_u.dac_din};
            nf++;
          end
        end else if (!ps) begin
          obs_u.push_back('{w, nf, sl});
          w = '0; nf = 0; sl = 0;
        end
        ps = if_u.dac_sync_n;
        pk = if_u.dac_sclk;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst_s = 1'b1;
    rst_u = 1'b1;
    if_s.sample_in = '0; if_s.sample_valid = 1'b0;
    if_u.sample_in = '0; if_u.sample_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_ready", if_s.sample_ready, 1);
    chk("rst_sync_n", if_s.dac_sync_n, 1);
    chk("rst_sclk", if_s.dac_sclk, 1);
    chk("rst_din", if_s.dac_din, 0);
    chk("rst_busy", if_s.busy, 0);
    chk("rst_ovr", if_s.overrun_cnt, 0);
    chk("rst_u_ready", if_u.sample_ready, 1);
    chk("rst_u_ovr", if_u.overrun_cnt, 0);
    #2;
    rst_s = 1'b0;
    rst_u = 1'b0;
    @(negedge clk);

    // Single signed frame, CLK_DIV=2
    drive_s(16'h8001, 1);
    t0 = cyc;
    chk("first_sync_n", if_s.dac_sync_n, 0);
    chk("first_sclk", if_s.dac_sclk, 1);
    chk("first_din", if_s.dac_din, 0);
    chk("first_ready", if_s.sample_ready, 0);
    chk("first_busy", if_s.busy, 1);
    while (cyc < t0 + 67) @(negedge clk);
    chk("ready_t68", if_s.sample_ready, 0);
    @(negedge clk);
    chk("ready_t69", if_s.sample_ready, 1);
    wait_s(200);
    drain_s();

    // Unsigned pass-through, CLK_DIV=1
    drive_u(16'hA5C3, 1);
    wait_u(200);
    drain_u();
    repeat (5) @(negedge clk);

    // Boundary: strobe on the GAP->IDLE edge is dropped, next cycle accepted
    drive_u(16'h0F0F, 1);
    t0 = cyc;
    while (cyc < t0 + 33) @(negedge clk);
    chk("bnd_gap_ready", if_u.sample_ready, 0);
    drive_u(16'h3C3C, 2);
    chk("bnd_ovr", if_u.overrun_cnt, ovr_u);
    chk("bnd_ready", if_u.sample_ready, 0);
    chk("bnd_busy", if_u.busy, 1);
    wait_u(200);
    drain_u();
    repeat (5) @(negedge clk);

    // Overrun: strobe every 10 cycles, then back-to-back until saturation
    #2 rst_u = 1'b1;
    @(negedge clk);
    #2 rst_u = 1'b0;
    free_u = 0;
    ovr_u  = 0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      drive_u(16'h1000 + 16'(i * 17), 1);
      repeat (9) @(negedge clk);
    end
    chk("ovr_20", if_u.overrun_cnt, ovr_u);
    wait_u(200);
    drain_u();
    drive_u(16'h4000, 300);
    chk("ovr_sat", if_u.overrun_cnt, ovr_u);
    wait_u(400);
    drain_u();

    // Reset mid-frame, then a clean frame
    drive_s(16'h7FFF, 1);
    t0 = cyc;
    while (cyc < t0 + 10) @(negedge clk);
    chk("mid_sync_n", if_s.dac_sync_n, 0);
    chk("mid_din", if_s.dac_din, 1);
    #2 rst_s = 1'b1;
    #1;
    chk("abort_sync_n", if_s.dac_sync_n, 1);
    chk("abort_sclk", if_s.dac_sclk, 1);
    chk("abort_din", if_s.dac_din, 0);
    chk("abort_busy", if_s.busy, 0);
    chk("abort_ready", if_s.sample_ready, 1);
    void'(exp_s.pop_back());
    repeat (2) @(negedge clk);
    #2 rst_s = 1'b0;
    free_s = 0;
    @(negedge clk);
    drive_s(16'h1234, 1);
    wait_s(200);
    drain_s();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
